// File: rtl/arb4_sched_pkg.sv
// Shared definitions for the four-way round-robin scheduler: FSM state
// encodings, the owner value loaded at reset, and the rotating search.
package arb4_sched_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_GAP  = 2'b10
    } arb_state_e;

    // Owner after reset is 3 so that the first search starts at requester 0.
    localparam logic [1:0] ARB_OWNER_RST = 2'b11;

    // Round-robin search: scan req starting at last+1 (mod 4), wrapping upward.
    // Returns {found, index}. The loop runs from the farthest candidate to the
    // nearest so the nearest set bit overwrites the others and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = {1'b0, last};
        for (int k = 4; k >= 1; k--) begin
            cand = last + k[1:0];
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/grant_decode.sv
// 2-to-4 one-hot decoder with enable; drives the per-requester grant lines
// from the registered owner index.
module grant_decode (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] grant
);

    // One-hot decode of idx, all zeros while disabled.
    always_comb begin
        grant = 4'b0000;
        if (en) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arb4_sched.sv
// Four-way round-robin scheduler for one shared downstream resource.
// Enforces a one-cycle dead gap between owners and an optional maximum hold
// time so that a busy requester cannot starve the others.
//
// Handshake: req[i] is a level request held by requester i for as long as it
// wants the resource. grant[i]=1 means requester i owns the resource in that
// cycle. The owner releases by dropping req[i]; the grant then falls on the
// following edge. A request is never acknowledged by anything other than its
// grant bit, and a requester must not assume ownership until grant[i] is seen.
module arb4_sched
    import arb4_sched_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic [1:0] fsm_state
);

    // MAX_HOLD of 0 disables forced rotation; the counter then just parks at
    // all ones and is never consulted.
    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_EN ? HOLD_W'(MAX_HOLD) : {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [1:0]        owner;
    logic [1:0]        owner_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [2:0]        pick;
    logic              others_waiting;
    logic              force_rot;
    logic              grant_en;

    // Candidate winner of the rotating search and rotation conditions.
    always_comb begin
        pick           = rr_pick(req, owner);
        others_waiting = |(req & ~(4'b0001 << owner));
        force_rot      = HOLD_EN && (hold_cnt >= HOLD_LAST) && others_waiting;
    end

    // State, owner and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            owner    <= ARB_OWNER_RST;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state logic: GAP arbitrates exactly like IDLE, so a requester that
    // just released only wins again when the search finds nobody else first.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        case (state)
            ARB_IDLE, ARB_GAP: begin
                if (pick[2]) begin
                    state_nxt = ARB_BUSY;
                    owner_nxt = pick[1:0];
                    hold_nxt  = '0;
                end else begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
                // Release and hold expiry on the same edge collapse into one GAP.
                if (!req[owner] || force_rot) begin
                    state_nxt = ARB_GAP;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Output decode, derived from registers only.
    always_comb begin
        grant_en    = (state == ARB_BUSY);
        grant_valid = grant_en;
        grant_idx   = owner;
        fsm_state   = state;
    end

    grant_decode u_grant_decode (
        .idx   (owner),
        .en    (grant_en),
        .grant (grant)
    );

endmodule

// File: tb/tb_arb4_sched.sv
// Bench for arb4_sched: two instances (hold limit 4 and unlimited) share one
// request stream and are compared against a request-level reference model.
module tb_arb4_sched;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req   = 4'b0000;

    logic [3:0] grant_a, grant_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b;
    logic [1:0] state_a, state_b;

    arb4_sched #(.MAX_HOLD(4), .HOLD_W(3)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant_a),
        .grant_idx   (idx_a),
        .grant_valid (valid_a),
        .fsm_state   (state_a)
    );

    arb4_sched #(.MAX_HOLD(0), .HOLD_W(5)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant_b),
        .grant_idx   (idx_b),
        .grant_valid (valid_b),
        .fsm_state   (state_b)
    );

    // Clock
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model, one slot per instance: who holds the resource now
    // (-1 = nobody), who held it last, and how many edges it has been held.
    int m_cur[2];
    int m_last[2];
    int m_held[2];
    int m_max[2] = '{4, 0};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int first_after(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cur[i]  = -1;
            m_last[i] = 3;
            m_held[i] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        for (int i = 0; i < 2; i++) begin
            if (m_cur[i] >= 0) begin
                m_held[i]++;
                others = r;
                others[m_cur[i]] = 1'b0;
                if (!r[m_cur[i]] || (m_max[i] > 0 && m_held[i] >= m_max[i] && others != 4'b0000)) begin
                    m_cur[i] = -1;
                end
            end else if (r != 4'b0000) begin
                m_cur[i]  = first_after(r, m_last[i]);
                m_last[i] = m_cur[i];
                m_held[i] = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_grant(input int i);
        logic [3:0] g;
        g = 4'b0000;
        if (m_cur[i] >= 0) g[m_cur[i]] = 1'b1;
        return g;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " a.grant"}, 32'(grant_a), 32'(exp_grant(0)));
        check({tag, " a.idx"},   32'(idx_a),   32'(m_last[0]));
        check({tag, " a.valid"}, 32'(valid_a), 32'(m_cur[0] >= 0));
        check({tag, " a.busy"},  32'(state_a == 2'b01), 32'(m_cur[0] >= 0));
        check({tag, " b.grant"}, 32'(grant_b), 32'(exp_grant(1)));
        check({tag, " b.idx"},   32'(idx_b),   32'(m_last[1]));
        check({tag, " b.valid"}, 32'(valid_b), 32'(m_cur[1] >= 0));
        check({tag, " b.busy"},  32'(state_b == 2'b01), 32'(m_cur[1] >= 0));
    endtask

    // One clock edge: advance the model with the sampled req, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_step(req);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset away from any edge; outputs must clear at once.
    task automatic do_reset(input logic [3:0] r_after);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        check("reset grant", 32'(grant_a), 32'h0);
        check("reset idx", 32'(idx_a), 32'h3);
        @(negedge clk);
        req   = r_after;
        rst_n = 1'b1;
    endtask

    // Directed step: one edge, compare grant of the limited instance, then
    // drive the next request pattern.
    task automatic step_exp(input string tag, input logic [3:0] g_exp, input logic [3:0] r_next);
        tick(tag);
        check({tag, " directed"}, 32'(grant_a), 32'(g_exp));
        req = r_next;
    endtask

    logic [3:0] t2_exp[12] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                               4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    logic [3:0] t2_req[12] = '{4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111, 4'b1111,
                               4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b1111, 4'b1111};
    logic [3:0] t3_exp[11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                               4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic [3:0] t6_exp[6]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100};
    logic [3:0] t6_req[6]  = '{4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0100};

    initial begin
        model_reset();
        #2;

        // Reset, first grant, then round-robin release
        do_reset(4'b1111);
        step_exp("t1 first grant", 4'b0001, 4'b1111);
        check("t1 valid", 32'(valid_a), 32'h1);
        for (int i = 0; i < 12; i++) begin
            step_exp("t2 rr release", t2_exp[i], t2_req[i]);
        end

        // Forced rotation with two constant requesters
        do_reset(4'b0011);
        for (int i = 0; i < 11; i++) begin
            step_exp("t3 forced", t3_exp[i], 4'b0011);
        end

        // Sole requester keeps the grant past the limit
        do_reset(4'b0100);
        for (int i = 0; i < 20; i++) begin
            step_exp("t4 sole", 4'b0100, (i == 19) ? 4'b0110 : 4'b0100);
        end
        step_exp("t4 rot gap", 4'b0000, 4'b0110);
        step_exp("t4 rot next", 4'b0010, 4'b0110);

        // Asynchronous reset mid-grant
        do_reset(4'b0010);
        step_exp("t5 grant", 4'b0010, 4'b0010);
        step_exp("t5 hold", 4'b0010, 4'b0010);
        #2;
        do_reset(4'b0010);
        step_exp("t5 regrant", 4'b0010, 4'b0010);
        check("t5 idx", 32'(idx_a), 32'h1);

        // Release coinciding with hold expiry
        do_reset(4'b0101);
        for (int i = 0; i < 6; i++) begin
            step_exp("t6 simul", t6_exp[i], t6_req[i]);
        end

        // Randomised traffic with occasional asynchronous resets
        req = 4'($urandom_range(15));
        for (int n = 0; n < 3000; n++) begin
            tick("rand");
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(499) == 0) do_reset(req);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
